// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bundle: PC controls, memory read port, branch redirect, decode handshake
interface fetch_unit_if;
    logic [31:0] pc_in;
    logic        pc_inc;
    logic        pc_jump;
    logic [31:0] pc_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        br_valid;
    logic [31:0] br_target;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir_out;
    logic [31:0] ir_pc;
    logic        fault;

    modport master (
        input  pc_in, mem_ack, mem_data, br_valid, br_target, ir_ready,
        output pc_inc, pc_jump, pc_target, mem_req, mem_addr,
               ir_valid, ir_out, ir_pc, fault
    );

    modport slave (
        output pc_in, mem_ack, mem_data, br_valid, br_target, ir_ready,
        input  pc_inc, pc_jump, pc_target, mem_req, mem_addr,
               ir_valid, ir_out, ir_pc, fault
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-buffer instruction fetch with branch redirect and memory watchdog
module fetch_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    logic [1:0]  state;
    logic [7:0]  wd_cnt;
    logic        ir_valid_q;
    logic [31:0] ir_out_q;
    logic [31:0] ir_pc_q;
    logic        fault_q;

    logic in_fetch;
    logic redirect;

    // Strobes are gated by reset so the PC never moves during the reset cycle.
    assign in_fetch = (state == S_FETCH) && !reset;
    assign redirect = bus.br_valid && !reset && (state != S_FAULT);

    assign bus.mem_req   = in_fetch;
    assign bus.mem_addr  = bus.pc_in;
    assign bus.pc_jump   = redirect;
    assign bus.pc_inc    = in_fetch && bus.mem_ack && !bus.br_valid;
    assign bus.pc_target = bus.br_valid ? bus.br_target : 32'd0;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.ir_out    = ir_out_q;
    assign bus.ir_pc     = ir_pc_q;
    assign bus.fault     = fault_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            wd_cnt     <= 8'd0;
            ir_valid_q <= 1'b0;
            ir_out_q   <= 32'd0;
            ir_pc_q    <= 32'd0;
            fault_q    <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (bus.br_valid) begin
                        wd_cnt <= 8'd0;
                    end else if (bus.mem_ack) begin
                        ir_out_q   <= bus.mem_data;
                        ir_pc_q    <= bus.pc_in;
                        ir_valid_q <= 1'b1;
                        wd_cnt     <= 8'd0;
                        state      <= S_HOLD;
                    end else if (wd_cnt == 8'(TIMEOUT - 1)) begin
                        fault_q <= 1'b1;
                        state   <= S_FAULT;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    // A redirect discards the held word even if decode is ready.
                    if (bus.br_valid || bus.ir_ready) begin
                        ir_valid_q <= 1'b0;
                        wd_cnt     <= 8'd0;
                        state      <= S_FETCH;
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a behavioural model
module tb_fetch_unit;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        reset;
    logic [31:0] pc_reg;

    fetch_unit_if bus();

    fetch_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Program counter register that the fetch stage steers.
    always @(posedge clk) begin
        if (reset)             pc_reg <= 32'd0;
        else if (bus.pc_jump)  pc_reg <= bus.pc_target;
        else if (bus.pc_inc)   pc_reg <= pc_reg + 32'd1;
    end
    assign bus.pc_in = pc_reg;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc;
    bit          m_have;
    bit          m_dead;
    int          m_waits;
    logic [31:0] m_ir;
    logic [31:0] m_irpc;
    bit          dir_data;

    logic [31:0] acc_pc[$];
    logic [31:0] acc_ir[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare against the model mid-cycle, then advance the model.
    task automatic step(input bit rst, input bit ack, input bit br, input logic [31:0] tgt,
                        input bit rdy, input bit chk);
        logic [31:0] data;
        bit          live;
        data = ack && dir_data ? 32'hA000_0000 + pc_reg : $urandom;
        reset         = rst;
        bus.mem_ack   = ack;
        bus.mem_data  = data;
        bus.br_valid  = br;
        bus.br_target = tgt;
        bus.ir_ready  = rdy;
        #4;
        live = !rst && !m_dead;
        if (chk) begin
            check("mem_req",   {31'd0, bus.mem_req},  {31'd0, live && !m_have});
            if (live && !m_have) check("mem_addr", bus.mem_addr, m_pc);
            check("pc_inc",    {31'd0, bus.pc_inc},   {31'd0, live && !m_have && ack && !br});
            check("pc_jump",   {31'd0, bus.pc_jump},  {31'd0, live && br});
            check("pc_target", bus.pc_target,         br ? tgt : 32'd0);
            check("ir_valid",  {31'd0, bus.ir_valid}, {31'd0, m_have});
            check("ir_out",    bus.ir_out,            m_ir);
            check("ir_pc",     bus.ir_pc,             m_irpc);
            check("fault",     {31'd0, bus.fault},    {31'd0, m_dead});
        end
        if (bus.ir_valid && rdy && !br && !rst) begin
            acc_pc.push_back(bus.ir_pc);
            acc_ir.push_back(bus.ir_out);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_pc = 0; m_have = 0; m_dead = 0; m_waits = 0; m_ir = 0; m_irpc = 0;
        end else if (m_dead) begin
            m_dead = 1;
        end else if (br) begin
            m_have = 0; m_waits = 0; m_pc = tgt;
        end else if (m_have) begin
            if (rdy) begin
                m_have = 0; m_waits = 0;
            end
        end else if (ack) begin
            m_have = 1; m_ir = data; m_irpc = m_pc; m_pc = m_pc + 1; m_waits = 0;
        end else begin
            m_waits++;
            if (m_waits == TIMEOUT) m_dead = 1;
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.mem_ack = 0; bus.mem_data = 0; bus.br_valid = 0; bus.br_target = 0; bus.ir_ready = 0;
        dir_data = 1;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1);

        // Zero-wait memory with decode always ready.
        acc_pc.delete(); acc_ir.delete();
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 1, 1);
        check("zw_count", acc_pc.size(), 4);
        for (int i = 0; i < 4 && i < acc_pc.size(); i++) begin
            check("zw_ir_pc", acc_pc[i], i);
            check("zw_ir_out", acc_ir[i], 32'hA000_0000 + i);
        end

        // Three wait cycles per fetch.
        for (int n = 0; n < 3; n++) begin
            for (int w = 0; w < 3; w++) step(0, 0, 0, 0, 1, 1);
            step(0, 1, 0, 0, 1, 1);
            step(0, 0, 0, 0, 1, 1);
        end

        // Decode stalls for five cycles in HOLD.
        step(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, $urandom_range(0, 1), 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1);
        step(0, 1, 0, 0, 1, 1);

        // Redirect coinciding with ack, then redirect during HOLD with decode ready.
        step(0, 0, 0, 0, 1, 1);
        step(0, 1, 1, 32'h40, 1, 1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 32'h80, 1, 1);
        step(0, 1, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);

        // Memory never acknowledges: watchdog fault, redirects ignored, reset recovers.
        step(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < TIMEOUT; i++) begin
            check("fault_early", {31'd0, bus.fault}, 32'd0);
            step(0, 0, 0, 0, 1, 1);
        end
        check("fault_set", {31'd0, bus.fault}, 32'd1);
        for (int i = 0; i < 5; i++) step(0, $urandom_range(0, 1), 1, $urandom, 1, 1);
        step(1, 0, 0, 0, 0, 1);
        check("fault_clr", {31'd0, bus.fault}, 32'd0);
        step(0, 1, 0, 0, 1, 1);

        // Reset while holding an instruction.
        step(0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        check("rst_hold_valid", {31'd0, bus.ir_valid}, 32'd0);
        check("rst_hold_ir", bus.ir_out, 32'd0);
        step(0, 0, 0, 0, 0, 1);

        // Randomized traffic.
        dir_data = 0;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 1,
                 $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 8,
                 $urandom_range(0, 3) == 0 ? 32'h40 : $urandom,
                 $urandom_range(0, 99) < 60,
                 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
